// File: rtl/weight_loader.sv
// weight_loader: accepts a valid/ready stream of weights and turns each
// accepted beat into one registered write into the weight memory. The 4-D
// write index (in, out, k_y, k_x) is walked with k_x innermost. When the full
// NUM_INPUTS*NUM_OUTPUTS*DIM*DIM tensor has been written, done pulses
// together with the final write.
//
// Optional build macro: WEIGHT_LOADER_CHECKSUM_EN adds a checksum output
// that XOR-accumulates every accepted beat of the current or last load.
//
// state | meaning
// IDLE  | waiting for start; s_ready low, no writes issued
// LOAD  | accepting beats; s_ready high, one write per accepted beat
module weight_loader #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DIM         = 1,
  parameter int DATA_SIZE   = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 write,
  output logic [15:0]          index_in,
  output logic [15:0]          index_out,
  output logic [15:0]          index_k_y,
  output logic [15:0]          index_k_x,
  output logic [DATA_SIZE-1:0] in_data,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     beat_count
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_SIZE-1:0] checksum
`endif
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [15:0]      IN_MAX  = 16'(NUM_INPUTS - 1);
  localparam logic [15:0]      OUT_MAX = 16'(NUM_OUTPUTS - 1);
  localparam logic [15:0]      DIM_MAX = 16'(DIM - 1);
  localparam logic [15:0]      ONE_16  = 16'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic [15:0] cnt_in, cnt_out, cnt_ky, cnt_kx;
  logic        accept, clear, last_beat;
  logic        kx_last, ky_last, out_last, in_last;

  assign kx_last   = (cnt_kx == DIM_MAX);
  assign ky_last   = (cnt_ky == DIM_MAX);
  assign out_last  = (cnt_out == OUT_MAX);
  assign in_last   = (cnt_in == IN_MAX);
  assign last_beat = kx_last & ky_last & out_last & in_last;

  // Next-state and handshake decode; s_ready and busy follow the state only.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    accept  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clear   = 1'b1;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        accept  = s_valid;
        if (s_valid && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Index counters: k_x innermost with carries outward; the last beat wraps
  // every counter back to zero so the next load starts at the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_in  <= '0;
      cnt_out <= '0;
      cnt_ky  <= '0;
      cnt_kx  <= '0;
    end else if (clear) begin
      cnt_in  <= '0;
      cnt_out <= '0;
      cnt_ky  <= '0;
      cnt_kx  <= '0;
    end else if (accept) begin
      if (kx_last) begin
        cnt_kx <= '0;
        if (ky_last) begin
          cnt_ky <= '0;
          if (out_last) begin
            cnt_out <= '0;
            cnt_in  <= in_last ? '0 : cnt_in + ONE_16;
          end else begin
            cnt_out <= cnt_out + ONE_16;
          end
        end else begin
          cnt_ky <= cnt_ky + ONE_16;
        end
      end else begin
        cnt_kx <= cnt_kx + ONE_16;
      end
    end
  end

  // Registered write port: one cycle from accept to write; index and data
  // hold their last values on cycles without an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write     <= 1'b0;
      done      <= 1'b0;
      index_in  <= '0;
      index_out <= '0;
      index_k_y <= '0;
      index_k_x <= '0;
      in_data   <= '0;
    end else begin
      write <= accept;
      done  <= accept & last_beat;
      if (accept) begin
        index_in  <= cnt_in;
        index_out <= cnt_out;
        index_k_y <= cnt_ky;
        index_k_x <= cnt_kx;
        in_data   <= s_data;
      end
    end
  end

  // Beat counter: cleared on start, holds its final value after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat_count <= '0;
    else if (clear)  beat_count <= '0;
    else if (accept) beat_count <= beat_count + CNT_ONE;
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  // XOR of every accepted beat since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum <= '0;
    else if (clear)  checksum <= '0;
    else if (accept) checksum <= checksum ^ s_data;
  end
`endif

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream feeder for the weight memory.
- Accepts a valid/ready stream of 64-bit weights (IEEE-754 double bit patterns) from the host/DMA side.
- Sequences the 4-D write index (in, out, k_y, k_x), with k_x innermost.
- Drives one registered write per accepted beat into the weight memory write port, and signals completion once the full NUM_INPUTS*NUM_OUTPUTS*DIM*DIM tensor is loaded.

Parameters:
- NUM_INPUTS, 1, input-channel count; outermost index range.
- NUM_OUTPUTS, 1, output-channel count.
- DIM, 1, square kernel side; range of k_y and k_x.
- DATA_SIZE, 64, weight word width.
- CNT_W, 16, width of the beat counter; must satisfy 2^CNT_W > NUM_INPUTS*NUM_OUTPUTS*DIM*DIM.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load when idle
- s_valid  input  1  upstream weight valid
- s_ready  output  1  loader can accept a beat
- s_data  input  DATA_SIZE  upstream weight
- write  output  1  write strobe to weight memory
- index_in  output  16  input-channel index
- index_out  output  16  output-channel index
- index_k_y  output  16  kernel row
- index_k_x  output  16  kernel column
- in_data  output  DATA_SIZE  weight to write
- busy  output  1  load in progress
- done  output  1  one-cycle pulse, coincident with the final write
- beat_count  output  CNT_W  beats accepted in current/last load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; write=0, done=0, busy=0, s_ready=0; all index outputs=0, in_data=0, beat_count=0; internal counters=0.
- FSM states: IDLE, LOAD.
- IDLE:
  - s_ready=0.
  - start=1 -> LOAD next cycle; internal counters and beat_count cleared to 0; busy=1 from that cycle.
- LOAD:
  - s_ready=1 combinationally.
  - Accept = s_valid & s_ready.
  - Per accept: on the next posedge write=1, index_* = current counter values, in_data=s_data; beat_count increments. Latency: one cycle from accept to write.
  - No accept: write=0 next cycle; index/in_data hold their last values.
- Counter order:
  - k_x increments each accept; wraps DIM-1 -> 0 and carries to k_y.
  - k_y wraps DIM-1 -> 0 and carries to out.
  - out wraps NUM_OUTPUTS-1 -> 0 and carries to in.
  - Single-valued dimensions (value 1) stay 0.
- Last beat: accept with all counters at maximum.
  - Next cycle: write=1 for that element, done=1, busy=0, state=IDLE.
  - Counters return to 0.
  - s_ready drops in the same cycle as the state change; no beat beyond the tensor size is ever accepted.
- start while in LOAD: ignored.
- start in the same cycle as the final write: ignored; a new load requires start while IDLE.
- Index outputs are zero-extended to 16 bits.
- beat_count holds its final value after done until the next start.
- Reset mid-load: everything returns to reset values immediately; a partially written memory is not rolled back.
- No write is issued in IDLE.

Optional Feature:
- Macro WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output checksum [DATA_SIZE-1:0].
  - Cleared on start.
  - XOR-accumulates s_data on every accept.
  - Holds after done; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle, with s_valid=1 and s_data=anything and no start -> s_ready=0, write=0, busy=0 for 10 cycles.
- NUM_INPUTS=2, NUM_OUTPUTS=2, DIM=3; start, then 36 back-to-back beats with s_data=k (k=0..35):
  - write asserted 36 cycles; the k-th write has in=k/18, out=(k/9)%2, ky=(k/3)%3, kx=k%3, in_data=k.
  - done pulses with the 36th write; beat_count=36.
  - s_ready=0 afterwards.
- Same config, s_valid toggled every other cycle -> write pattern follows accepts with 1-cycle lag; index sequence identical to the previous test; done after 36 accepts.
- start pulsed again at beat 10 of a load -> no effect; sequence continues; done after beat 36.
- rst_n driven low at beat 20, then start again -> outputs zero asynchronously; new load restarts at index (0,0,0,0); beat_count restarts from 0.
- With WEIGHT_LOADER_CHECKSUM_EN, DIM=2, NUM_INPUTS=NUM_OUTPUTS=1, data 0x1,0x2,0x4,0x8 -> checksum=0xF at done; checksum=0 after the next start.
